regfile_pair: RTL and testbench
===============================

# regfile_pair

Parametrised general-purpose register file for the core, the successor to the plain byte register file. It adds 16-bit register-pair access (BC/DE/HL style), a single-cycle pair increment/decrement with a zero indication, a per-bit masked flag update and write-through bypass on both registered read ports. It sits between the decoder/ALU and the address-generation path of the datapath.

## Interface
- DATASIZE, 8: width of one register.
- ADDRSIZE, 3: register address width. RCOUNT = 2**ADDRSIZE registers; RCOUNT/2 pairs. ADDRSIZE >= 1.
- FLAGMASK, 8'hD5: implemented flag bits (S Z AC P CY); DATASIZE wide.
- FLAGFIX, 8'h02: value read back on unimplemented flag bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- wrenb  in  1  byte write enable.
- waddr  in  ADDRSIZE  byte write address.
- wdata  in  DATASIZE  byte write data.
- pwenb  in  1  pair write enable.
- paddr  in  ADDRSIZE-1  pair index for write, inc/dec and prdat.
- pwdat  in  2*DATASIZE  pair write data, high byte first.
- pinc  in  1  increment pair at paddr.
- pdec  in  1  decrement pair at paddr.
- flenb  in  1  flag update enable.
- flmsk  in  DATASIZE  per-bit flag update mask.
- ifdat  in  DATASIZE  new flag values.
- r1enb, r2enb  in  1  read port enables.
- r1add, r2add  in  ADDRSIZE  read port addresses.
- r1dat, r2dat  out  DATASIZE  registered read data.
- prdat  out  2*DATASIZE  combinational pair value at paddr.
- pzero  out  1  registered: last inc/dec produced 0.
- ofdat  out  DATASIZE  flag register view.

## Operation
- Pair p = {reg[2p] (high), reg[2p+1] (low)}.
- Byte write: reg[waddr] <= wdata when wrenb.
- Pair write: pair[paddr] <= pwdat when pwenb.
- Inc/dec:
  - Applies when exactly one of pinc/pdec is high: pair[paddr] <= pair ± 1, modulo 2**(2*DATASIZE).
  - pinc and pdec together: no inc/dec and no pair write; pzero holds.
- Per-register priority, highest first: inc/dec, pwenb, wrenb. Losers are dropped only on registers they share; writes to disjoint registers all complete in the same edge.
- pzero: on an edge with a valid inc/dec, pzero <= (result == 0). On all other edges it holds.
- Flags: flag[i] <= flmsk[i] ? ifdat[i] : flag[i] when flenb. ofdat = (flag & FLAGMASK) | (FLAGFIX & ~FLAGMASK).
- Read ports:
  - When rNenb is high, rNdat <= the post-edge value of reg[rNadd], including all same-edge writes (bypass).
  - When rNenb is low, rNdat holds.
- prdat reflects current register contents and does not bypass pending writes.

## Timing
- Reset (rst low at a rising edge): all registers, flags, r1dat, r2dat and pzero become 0. ofdat reads FLAGFIX & ~FLAGMASK.
  - Reset overrides every enable in the same cycle. An inc/dec or write coinciding with reset is lost.
- Write latency is 1 edge. Read latency is 1 edge; a write and a read of the same address on one edge return the new data.
- prdat changes within the cycle following the write edge (combinational from state).
- Wrap cases:
  - 0xFFFF + pinc gives 0x0000, pzero = 1.
  - 0x0001 + pdec gives 0x0000, pzero = 1.
  - 0x0000 + pdec gives 0xFFFF, pzero = 0.

## Structure
- Shared package regfile_pkg:
  - flag bit positions FLAG_S=7, FLAG_Z=6, FLAG_AC=4, FLAG_P=2, FLAG_CY=0;
  - default FLAGMASK and FLAGFIX;
  - pair index constants PAIR_BC=0, PAIR_DE=1, PAIR_HL=2.
- Storage uses the existing `register` cell, one per register, in generate block reg_block[i].regs with output data_out. Existing hierarchical bench probes remain valid.
- Next-state mux, with priority and bypass, lives in the top level. The flag register is a separate `register` instance.

## Test plan
- Reset: hold rst low for 5 cycles. All reg_block[i].regs.data_out = 00, r1dat = 00, pzero = 0, ofdat = 02.
- Byte write with bypass: wrenb, waddr=1, wdata=AA, r1enb, r1add=1 on the same edge gives r1dat=AA on that edge. Then read port 2 at address 0 reads 00.
- Pair write and collision:
  - pwenb, paddr=2, pwdat=1234 gives reg4=12, reg5=34, prdat=1234.
  - Same edge with wrenb to reg5=FF gives reg5=34.
  - Same edge with wrenb to reg0=FF gives reg0=FF.
- Inc/dec wrap:
  - Pair 1 = FFFF, pinc gives 0000 with pzero=1.
  - pdec gives FFFF with pzero=0.
  - pinc and pdec together leave FFFF with pzero held.
- Masked flags: flenb, flmsk=FF, ifdat=FF gives ofdat=D7. Then flmsk=01, ifdat=00 gives ofdat=D6.
- Reset mid-operation: pinc asserted with rst low on the same edge gives pair 0000, pzero=0. Operation resumes normally on the next edge after rst is released.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-pair file: flag bit positions, flag
// defaults and the conventional pair indices.
package regfile_pkg;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_AC = 4;
  localparam int FLAG_P  = 2;
  localparam int FLAG_CY = 0;

  localparam logic [7:0] DEF_FLAGMASK = 8'hD5;
  localparam logic [7:0] DEF_FLAGFIX  = 8'h02;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;

endpackage

// File: rtl/regfile_pair_register.sv
// Generic storage cell: one register with load enable and synchronous
// active-low clear.
module register
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (!rst)     data_out <= '0;
    else if (enb) data_out <= data_in;
  end

endmodule

// File: rtl/regfile_pair.sv
// Byte register file with 16-bit pair write/inc/dec, masked flag update and
// write-through bypass on both registered read ports.
module regfile_pair
  import regfile_pkg::*;
#(
  parameter int                  DATASIZE = 8,
  parameter int                  ADDRSIZE = 3,
  parameter logic [DATASIZE-1:0] FLAGMASK = DATASIZE'(DEF_FLAGMASK),
  parameter logic [DATASIZE-1:0] FLAGFIX  = DATASIZE'(DEF_FLAGFIX),
  localparam int RCOUNT = 2**ADDRSIZE,
  localparam int PCOUNT = RCOUNT/2,
  localparam int PW     = (ADDRSIZE > 1) ? ADDRSIZE-1 : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrenb,
  input  logic [ADDRSIZE-1:0]   waddr,
  input  logic [DATASIZE-1:0]   wdata,
  input  logic                  pwenb,
  input  logic [PW-1:0]         paddr,
  input  logic [2*DATASIZE-1:0] pwdat,
  input  logic                  pinc,
  input  logic                  pdec,
  input  logic                  flenb,
  input  logic [DATASIZE-1:0]   flmsk,
  input  logic [DATASIZE-1:0]   ifdat,
  input  logic                  r1enb,
  input  logic [ADDRSIZE-1:0]   r1add,
  input  logic                  r2enb,
  input  logic [ADDRSIZE-1:0]   r2add,
  output logic [DATASIZE-1:0]   r1dat,
  output logic [DATASIZE-1:0]   r2dat,
  output logic [2*DATASIZE-1:0] prdat,
  output logic                  pzero,
  output logic [DATASIZE-1:0]   ofdat
);

  logic [RCOUNT-1:0][DATASIZE-1:0]   reg_q, reg_d, reg_nxt;
  logic [RCOUNT-1:0]                 reg_en;
  logic [PCOUNT-1:0][2*DATASIZE-1:0] pair_q;
  logic [2*DATASIZE-1:0]             pair_inc, pair_new;
  logic                              incdec_v, pair_we;
  logic [DATASIZE-1:0]               flag_q, flag_d, r1dat_q, r2dat_q;
  logic                              pzero_q;

  for (genvar i = 0; i < RCOUNT; i++) begin : reg_block
    register #(.WIDTH(DATASIZE)) regs (
      .clk(clk), .rst(rst), .enb(reg_en[i]), .data_in(reg_d[i]), .data_out(reg_q[i])
    );
  end

  for (genvar p = 0; p < PCOUNT; p++) begin : pair_view
    assign pair_q[p] = {reg_q[2*p], reg_q[2*p+1]};
  end

  assign prdat    = pair_q[paddr];
  // pinc and pdec together cancel each other and also suppress the pair write
  assign incdec_v = pinc ^ pdec;
  assign pair_we  = incdec_v | (pwenb & ~(pinc & pdec));
  assign pair_inc = pinc ? prdat + (2*DATASIZE)'(1) : prdat - (2*DATASIZE)'(1);
  assign pair_new = incdec_v ? pair_inc : pwdat;

  // Byte write first, pair path overrides it only on the two registers it owns
  always_comb begin
    for (int i = 0; i < RCOUNT; i++) begin
      reg_en[i] = 1'b0;
      reg_d[i]  = wdata;
      if (wrenb && waddr == ADDRSIZE'(i)) reg_en[i] = 1'b1;
      if (pair_we && paddr == PW'(i/2)) begin
        reg_en[i] = 1'b1;
        reg_d[i]  = (i % 2 == 0) ? pair_new[2*DATASIZE-1 -: DATASIZE] : pair_new[DATASIZE-1:0];
      end
      reg_nxt[i] = reg_en[i] ? reg_d[i] : reg_q[i];
    end
  end

  assign flag_d = (flmsk & ifdat) | (~flmsk & flag_q);

  register #(.WIDTH(DATASIZE)) flag_reg (
    .clk(clk), .rst(rst), .enb(flenb), .data_in(flag_d), .data_out(flag_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r1dat_q <= '0;
      r2dat_q <= '0;
      pzero_q <= 1'b0;
    end else begin
      if (r1enb)    r1dat_q <= reg_nxt[r1add];
      if (r2enb)    r2dat_q <= reg_nxt[r2add];
      if (incdec_v) pzero_q <= (pair_inc == '0);
    end
  end

  assign r1dat = r1dat_q;
  assign r2dat = r2dat_q;
  assign pzero = pzero_q;
  assign ofdat = (flag_q & FLAGMASK) | (FLAGFIX & ~FLAGMASK);

endmodule

// File: tb/tb_regfile_pair.sv
// Directed vector bench for regfile_pair: table of single-edge operations with
// hand-computed results, plus reset and hierarchical storage checks.
module tb_regfile_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrenb, pwenb, pinc, pdec, flenb, r1enb, r2enb;
  logic [2:0]  waddr, r1add, r2add;
  logic [1:0]  paddr;
  logic [7:0]  wdata, flmsk, ifdat, r1dat, r2dat, ofdat;
  logic [15:0] pwdat, prdat;
  logic        pzero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_pair dut (
    .clk(clk), .rst(rst), .wrenb(wrenb), .waddr(waddr), .wdata(wdata),
    .pwenb(pwenb), .paddr(paddr), .pwdat(pwdat), .pinc(pinc), .pdec(pdec),
    .flenb(flenb), .flmsk(flmsk), .ifdat(ifdat),
    .r1enb(r1enb), .r1add(r1add), .r2enb(r2enb), .r2add(r2add),
    .r1dat(r1dat), .r2dat(r2dat), .prdat(prdat), .pzero(pzero), .ofdat(ofdat)
  );

  typedef struct {
    logic        wrenb; logic [2:0] waddr; logic [7:0] wdata;
    logic        pwenb; logic [1:0] paddr; logic [15:0] pwdat;
    logic        pinc;  logic pdec;
    logic        flenb; logic [7:0] flmsk; logic [7:0] ifdat;
    logic        r1enb; logic [2:0] r1add; logic r2enb; logic [2:0] r2add;
    logic [7:0]  e_r1;  logic [7:0] e_r2; logic [15:0] e_pr; logic e_pz; logic [7:0] e_of;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic we, input logic [2:0] wa, input logic [7:0] wd,
    input logic pw, input logic [1:0] pa, input logic [15:0] pd,
    input logic pi, input logic pde,
    input logic fe, input logic [7:0] fm, input logic [7:0] fd,
    input logic e1, input logic [2:0] a1, input logic e2, input logic [2:0] a2,
    input logic [7:0] x1, input logic [7:0] x2, input logic [15:0] xp,
    input logic xz, input logic [7:0] xo);
    vec_t v;
    v.wrenb = we; v.waddr = wa; v.wdata = wd;
    v.pwenb = pw; v.paddr = pa; v.pwdat = pd; v.pinc = pi; v.pdec = pde;
    v.flenb = fe; v.flmsk = fm; v.ifdat = fd;
    v.r1enb = e1; v.r1add = a1; v.r2enb = e2; v.r2add = a2;
    v.e_r1 = x1; v.e_r2 = x2; v.e_pr = xp; v.e_pz = xz; v.e_of = xo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wrenb = 0; waddr = 0; wdata = 0; pwenb = 0; paddr = 0; pwdat = 0;
    pinc = 0; pdec = 0; flenb = 0; flmsk = 0; ifdat = 0;
    r1enb = 0; r1add = 0; r2enb = 0; r2add = 0;
  endtask

  task automatic drive(input vec_t v);
    wrenb = v.wrenb; waddr = v.waddr; wdata = v.wdata;
    pwenb = v.pwenb; paddr = v.paddr; pwdat = v.pwdat; pinc = v.pinc; pdec = v.pdec;
    flenb = v.flenb; flmsk = v.flmsk; ifdat = v.ifdat;
    r1enb = v.r1enb; r1add = v.r1add; r2enb = v.r2enb; r2add = v.r2add;
  endtask

  initial begin
    //          we wa wdata pw pa pwdat    pi pd fe flmsk ifdat e1 a1 e2 a2  r1     r2     prdat     pz of
    vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'hAA, 8'h00, 16'h00AA, 0, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'hAA, 8'h00, 16'h00AA, 0, 8'h02));
    vecs.push_back(mk(1, 5, 8'hFF, 1, 2, 16'h1234, 0, 0, 0, 8'h00, 8'h00, 1, 5, 1, 4, 8'h34, 8'h12, 16'h1234, 0, 8'h02));
    vecs.push_back(mk(1, 0, 8'hFF, 1, 2, 16'h5678, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 5, 8'hFF, 8'h78, 16'h5678, 0, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 16'hFFFF, 0, 0, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'hFF, 8'hFF, 16'hFFFF, 0, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00, 16'h0000, 1, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'hFF, 8'hFF, 16'hFFFF, 0, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 16'h1234, 1, 1, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'hFF, 8'hFF, 16'hFFFF, 0, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16'h0000, 1, 0, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00, 16'h0000, 1, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 16'h1234, 1, 1, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00, 16'h0000, 1, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 16'h0001, 0, 0, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'h00, 8'h01, 16'h0001, 1, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00, 16'h0000, 1, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'hFF, 8'hFF, 16'hFFFF, 0, 8'h02));
    vecs.push_back(mk(1, 3, 8'h55, 0, 1, 16'h0000, 1, 0, 0, 8'h00, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00, 16'h0000, 1, 8'h02));
    vecs.push_back(mk(1, 6, 8'h77, 0, 1, 16'h0000, 0, 1, 0, 8'h00, 8'h00, 1, 6, 1, 2, 8'h77, 8'hFF, 16'hFFFF, 0, 8'h02));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 1, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h77, 8'hFF, 16'hFFAA, 0, 8'hD7));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 1, 8'h01, 8'h00, 0, 0, 0, 0, 8'h77, 8'hFF, 16'hFFAA, 0, 8'hD6));
    vecs.push_back(mk(1, 7, 8'h3C, 0, 3, 16'h0000, 0, 0, 0, 8'hFF, 8'h00, 1, 7, 0, 0, 8'h3C, 8'hFF, 16'h773C, 0, 8'hD6));

    idle();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reset_reg%0d", i), {8'h00, dut.reg_q[i]}, 16'h0000);
    chk("reset_hier_reg0", {8'h00, dut.reg_block[0].regs.data_out}, 16'h0000);
    chk("reset_hier_reg7", {8'h00, dut.reg_block[7].regs.data_out}, 16'h0000);
    chk("reset_r1dat", {8'h00, r1dat}, 16'h0000);
    chk("reset_r2dat", {8'h00, r2dat}, 16'h0000);
    chk("reset_pzero", {15'h0, pzero}, 16'h0000);
    chk("reset_ofdat", {8'h00, ofdat}, 16'h0002);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_r1dat", i), {8'h00, r1dat}, {8'h00, vecs[i].e_r1});
      chk($sformatf("v%0d_r2dat", i), {8'h00, r2dat}, {8'h00, vecs[i].e_r2});
      chk($sformatf("v%0d_prdat", i), prdat, vecs[i].e_pr);
      chk($sformatf("v%0d_pzero", i), {15'h0, pzero}, {15'h0, vecs[i].e_pz});
      chk($sformatf("v%0d_ofdat", i), {8'h00, ofdat}, {8'h00, vecs[i].e_of});
    end

    idle();
    @(posedge clk);
    #1;
    chk("hier_reg0", {8'h00, dut.reg_block[0].regs.data_out}, 16'h00FF);
    chk("hier_reg1", {8'h00, dut.reg_block[1].regs.data_out}, 16'h00AA);
    chk("hier_reg3", {8'h00, dut.reg_block[3].regs.data_out}, 16'h00FF);
    chk("hier_reg4", {8'h00, dut.reg_block[4].regs.data_out}, 16'h0056);
    chk("hier_reg5", {8'h00, dut.reg_block[5].regs.data_out}, 16'h0078);
    chk("hier_reg6", {8'h00, dut.reg_block[6].regs.data_out}, 16'h0077);

    // Reset wins over an inc on the same edge, then normal operation resumes
    paddr = 2'd1; pinc = 1'b1; r1enb = 1'b1; r1add = 3'd7; rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstinc_prdat", prdat, 16'h0000);
    chk("rstinc_pzero", {15'h0, pzero}, 16'h0000);
    chk("rstinc_r1dat", {8'h00, r1dat}, 16'h0000);
    chk("rstinc_ofdat", {8'h00, ofdat}, 16'h0002);
    chk("rstinc_reg7", {8'h00, dut.reg_block[7].regs.data_out}, 16'h0000);
    rst = 1'b1; r1enb = 1'b0;
    @(posedge clk);
    #1;
    chk("resume_inc_prdat", prdat, 16'h0001);
    chk("resume_inc_pzero", {15'h0, pzero}, 16'h0000);
    pinc = 1'b0; pdec = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_dec_prdat", prdat, 16'h0000);
    chk("resume_dec_pzero", {15'h0, pzero}, 16'h0001);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
